// File: rtl/rv_mem_if.sv
// +----------------------------------------------------------------------+
// | Module  : rv_mem_if                                                  |
// | Brief   : Data-memory request/response channel for the Q103H stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface rv_mem_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/rv_mem.sv
// +----------------------------------------------------------------------+
// | Module  : rv_mem                                                     |
// | Brief   : RV32I memory-access stage (Q103H -> Q104H) with            |
// |           variable-latency data memory and load timeout.             |
// |           Optional macro: RV_MEM_MISALIGN_TRAP_EN                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rv_mem #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        valid_Q103H,
    input  wire logic        mem_rd_Q103H,
    input  wire logic        mem_wr_Q103H,
    input  wire logic [1:0]  mem_size_Q103H,
    input  wire logic        mem_unsigned_Q103H,
    input  wire logic [1:0]  sel_wb_Q103H,
    input  wire logic [31:0] alu_out_Q103H,
    input  wire logic [31:0] dmem_wr_data_Q103H,
    input  wire logic [31:0] pc_plus4_Q103H,
    output logic             ready_Q103H,
    output logic [31:0]      wb_data_Q103H,
    output logic             misalign_Q103H,
    output logic [31:0]      wb_data_Q104H,
    output logic             bus_err_Q104H,
    rv_mem_if.master         dmem
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic        w_is_byte;
    logic        w_is_half;
    logic [1:0]  w_addr_lo;
    logic [1:0]  w_off;
    logic        w_mem_op;
    logic        w_trap;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;
    logic [31:0] w_load_val;
    logic        w_bus_err;
    logic        w_req_valid;
    logic        w_ready;
    logic [31:0] w_wb_nonmem;
    logic [31:0] w_wb_q104;

    assign w_is_byte = (mem_size_Q103H == 2'b00);
    assign w_is_half = (mem_size_Q103H == 2'b01);
    assign w_addr_lo = alu_out_Q103H[1:0];
    assign w_mem_op  = valid_Q103H & (mem_rd_Q103H | mem_wr_Q103H);

    // Lane offset drops address bits below the access size, so a misaligned
    // access that is allowed through lands on its naturally aligned lanes.
    assign w_off = w_is_byte ? w_addr_lo :
                   w_is_half ? {w_addr_lo[1], 1'b0} : 2'b00;

`ifdef RV_MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_is_half & w_addr_lo[0]) |
                        (mem_size_Q103H[1] & (w_addr_lo != 2'b00));
    assign w_trap         = w_mem_op & w_misalign;
    assign misalign_Q103H = w_trap;
`else
    assign w_trap         = 1'b0;
    assign misalign_Q103H = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = dmem_wr_data_Q103H;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{dmem_wr_data_Q103H[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{dmem_wr_data_Q103H[15:0]}};
        end
    end

    assign w_shifted = dmem.dmem_rsp_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        if (w_is_byte) begin
            w_load_ext = {{24{~mem_unsigned_Q103H & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_load_ext = {{16{~mem_unsigned_Q103H & w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    always_comb begin
        case (sel_wb_Q103H)
            2'b00:   w_wb_nonmem = alu_out_Q103H;
            2'b10:   w_wb_nonmem = pc_plus4_Q103H;
            default: w_wb_nonmem = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_valid = 1'b0;
        w_ready     = 1'b1;
        w_load_val  = 32'h0;
        w_bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_trap) begin
                    w_req_valid = 1'b1;
                    if (dmem.dmem_req_ready) begin
                        if (mem_rd_Q103H) begin
                            w_ready     = 1'b0;
                            w_state_nxt = S_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_ready = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (dmem.dmem_rsp_valid) begin
                    w_load_val  = w_load_ext;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_ready   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Hold the handshake outputs at their idle values while reset is asserted.
        if (!rst) begin
            w_req_valid = 1'b0;
            w_ready     = 1'b1;
        end
    end

    assign ready_Q103H          = w_ready;
    assign dmem.dmem_req_valid  = w_req_valid;
    assign dmem.dmem_req_addr   = {alu_out_Q103H[31:2], 2'b00};
    assign dmem.dmem_req_we     = mem_wr_Q103H;
    assign dmem.dmem_req_be     = w_be;
    assign dmem.dmem_req_wdata  = w_wdata;
    assign wb_data_Q103H        = w_wb_nonmem;

    assign w_wb_q104 = w_trap ? 32'h0 :
                       (sel_wb_Q103H == 2'b01) ? w_load_val : w_wb_nonmem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_Q104H <= 32'h0;
            bus_err_Q104H <= 1'b0;
        end else if (w_ready) begin
            wb_data_Q104H <= w_wb_q104;
            bus_err_Q104H <= w_bus_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_mem.sv
// +----------------------------------------------------------------------+
// | Module  : tb_rv_mem                                                  |
// | Brief   : Directed self-checking bench for rv_mem (TIMEOUT_CYCLES=4).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rv_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_Q103H = 1'b0;
    logic        mem_rd_Q103H = 1'b0;
    logic        mem_wr_Q103H = 1'b0;
    logic [1:0]  mem_size_Q103H = 2'b00;
    logic        mem_unsigned_Q103H = 1'b0;
    logic [1:0]  sel_wb_Q103H = 2'b00;
    logic [31:0] alu_out_Q103H = 32'h0;
    logic [31:0] dmem_wr_data_Q103H = 32'h0;
    logic [31:0] pc_plus4_Q103H = 32'h0;
    logic        ready_Q103H;
    logic [31:0] wb_data_Q103H;
    logic        misalign_Q103H;
    logic [31:0] wb_data_Q104H;
    logic        bus_err_Q104H;

    rv_mem_if dmem ();

    rv_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_Q103H        (valid_Q103H),
        .mem_rd_Q103H       (mem_rd_Q103H),
        .mem_wr_Q103H       (mem_wr_Q103H),
        .mem_size_Q103H     (mem_size_Q103H),
        .mem_unsigned_Q103H (mem_unsigned_Q103H),
        .sel_wb_Q103H       (sel_wb_Q103H),
        .alu_out_Q103H      (alu_out_Q103H),
        .dmem_wr_data_Q103H (dmem_wr_data_Q103H),
        .pc_plus4_Q103H     (pc_plus4_Q103H),
        .ready_Q103H        (ready_Q103H),
        .wb_data_Q103H      (wb_data_Q103H),
        .misalign_Q103H     (misalign_Q103H),
        .wb_data_Q104H      (wb_data_Q104H),
        .bus_err_Q104H      (bus_err_Q104H),
        .dmem               (dmem.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] wb;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] wb, input logic err);
        exp_t e;
        e.wb  = wb;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_wb"}, wb_data_Q104H, e.wb);
            chk({tag, "_err"}, {31'd0, bus_err_Q104H}, {31'd0, e.err});
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4);
        valid_Q103H        = v;
        mem_rd_Q103H       = rd;
        mem_wr_Q103H       = wr;
        mem_size_Q103H     = size;
        mem_unsigned_Q103H = uns;
        sel_wb_Q103H       = sel;
        alu_out_Q103H      = alu;
        dmem_wr_data_Q103H = wd;
        pc_plus4_Q103H     = pc4;
    endtask

    initial begin
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rsp_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_wb", wb_data_Q104H, 32'h0);
        chk("rst_err", {31'd0, bus_err_Q104H}, 32'd0);
        chk("rst_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        chk("rst_ready", {31'd0, ready_Q103H}, 32'd1);
        rst = 1'b1;
        tick();

        // Store byte, immediate accept
        set_op(1, 0, 1, 2'b00, 0, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0);
        dmem.dmem_req_ready = 1'b1;
        #1;
        chk("sb_addr", dmem.dmem_req_addr, 32'h0000_1000);
        chk("sb_be", {28'd0, dmem.dmem_req_be}, 32'h8);
        chk("sb_wdata", dmem.dmem_req_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'd0, dmem.dmem_req_we}, 32'd1);
        chk("sb_reqv", {31'd0, dmem.dmem_req_valid}, 32'd1);
        chk("sb_ready", {31'd0, ready_Q103H}, 32'd1);
        chk("sb_fwd", wb_data_Q103H, 32'h0000_1003);
        push(32'h0000_1003, 1'b0);
        tick();
        sb_check("sb");

        // Signed load-half, response 3 cycles after accept
        set_op(1, 1, 0, 2'b01, 0, 2'b01, 32'h0000_2002, 32'h0, 32'h0);
        #1;
        chk("lh_addr", dmem.dmem_req_addr, 32'h0000_2000);
        chk("lh_be", {28'd0, dmem.dmem_req_be}, 32'hC);
        chk("lh_we", {31'd0, dmem.dmem_req_we}, 32'd0);
        chk("lh_fwd", wb_data_Q103H, 32'h0);
        chk("lh_stall0", {31'd0, ready_Q103H}, 32'd0);
        tick();
        dmem.dmem_req_ready = 1'b0;
        #1;
        chk("lh_wait_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        chk("lh_stall1", {31'd0, ready_Q103H}, 32'd0);
        tick();
        chk("lh_stall2", {31'd0, ready_Q103H}, 32'd0);
        tick();
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_rdata = 32'h8001_1234;
        #1;
        chk("lh_done", {31'd0, ready_Q103H}, 32'd1);
        push(32'hFFFF_8001, 1'b0);
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        sb_check("lh");

        // LHU, zero-wait memory: exactly one stall cycle
        set_op(1, 1, 0, 2'b01, 1, 2'b01, 32'h0000_2002, 32'h0, 32'h0);
        dmem.dmem_req_ready = 1'b1;
        #1;
        chk("lhu_stall", {31'd0, ready_Q103H}, 32'd0);
        tick();
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b1;
        #1;
        chk("lhu_done", {31'd0, ready_Q103H}, 32'd1);
        push(32'h0000_8001, 1'b0);
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        sb_check("lhu");

        // Store half with req_ready low for 2 cycles
        set_op(1, 0, 1, 2'b01, 0, 2'b10, 32'h0000_4002, 32'h1234_BEEF, 32'h0000_0108);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("sh_reqv", {31'd0, dmem.dmem_req_valid}, 32'd1);
            chk("sh_addr", dmem.dmem_req_addr, 32'h0000_4000);
            chk("sh_be", {28'd0, dmem.dmem_req_be}, 32'hC);
            chk("sh_wdata", dmem.dmem_req_wdata, 32'hBEEF_BEEF);
            chk("sh_stall", {31'd0, ready_Q103H}, 32'd0);
            tick();
        end
        dmem.dmem_req_ready = 1'b1;
        #1;
        chk("sh_ready3", {31'd0, ready_Q103H}, 32'd1);
        chk("sh_fwd", wb_data_Q103H, 32'h0000_0108);
        push(32'h0000_0108, 1'b0);
        tick();
        sb_check("sh");

        // Load word, no response: timeout on 4th WAIT cycle
        set_op(1, 1, 0, 2'b10, 0, 2'b01, 32'h0000_5000, 32'h0, 32'h0);
        #1;
        chk("to_stall0", {31'd0, ready_Q103H}, 32'd0);
        tick();
        dmem.dmem_req_ready = 1'b0;
        #1;
        chk("to_w1", {31'd0, ready_Q103H}, 32'd0);
        tick();
        chk("to_w2", {31'd0, ready_Q103H}, 32'd0);
        tick();
        chk("to_w3", {31'd0, ready_Q103H}, 32'd0);
        tick();
        chk("to_w4", {31'd0, ready_Q103H}, 32'd1);
        push(32'h0, 1'b1);
        tick();
        sb_check("to");

        // Late response in IDLE is ignored
        set_op(0, 0, 0, 2'b10, 0, 2'b01, 32'h0, 32'h0, 32'h0);
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("late_ready", {31'd0, ready_Q103H}, 32'd1);
        chk("late_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        push(32'h0, 1'b0);
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        sb_check("late");

        // Signed byte load at lane 1
        set_op(1, 1, 0, 2'b00, 0, 2'b01, 32'h0000_6001, 32'h0, 32'h0);
        dmem.dmem_req_ready = 1'b1;
        #1;
        chk("lb_be", {28'd0, dmem.dmem_req_be}, 32'h2);
        tick();
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_rdata = 32'h0000_8000;
        #1;
        chk("lb_done", {31'd0, ready_Q103H}, 32'd1);
        push(32'hFFFF_FF80, 1'b0);
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        sb_check("lb");

        // Misaligned load word at 0x3001
        set_op(1, 1, 0, 2'b10, 0, 2'b01, 32'h0000_3001, 32'h0, 32'h0);
        dmem.dmem_req_ready = 1'b1;
        #1;
`ifdef RV_MEM_MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, misalign_Q103H}, 32'd1);
        chk("mis_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        chk("mis_ready", {31'd0, ready_Q103H}, 32'd1);
        push(32'h0, 1'b0);
        tick();
        dmem.dmem_req_ready = 1'b0;
        sb_check("mis");
`else
        chk("mis_flag", {31'd0, misalign_Q103H}, 32'd0);
        chk("mis_reqv", {31'd0, dmem.dmem_req_valid}, 32'd1);
        chk("mis_addr", dmem.dmem_req_addr, 32'h0000_3000);
        chk("mis_be", {28'd0, dmem.dmem_req_be}, 32'hF);
        tick();
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_rdata = 32'hCAFE_F00D;
        #1;
        push(32'hCAFE_F00D, 1'b0);
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        sb_check("mis");
`endif

        // Reset asserted mid-WAIT, then a stray response
        set_op(1, 1, 0, 2'b10, 0, 2'b01, 32'h0000_7000, 32'h0, 32'h0);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        #1;
        chk("rw_stall", {31'd0, ready_Q103H}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rw_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        chk("rw_ready", {31'd0, ready_Q103H}, 32'd1);
        chk("rw_wb", wb_data_Q104H, 32'h0);
        chk("rw_err", {31'd0, bus_err_Q104H}, 32'd0);
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_rdata = 32'h1234_5678;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        tick();
        chk("rw_wb_hold", wb_data_Q104H, 32'h0);
        set_op(0, 0, 0, 2'b00, 0, 2'b00, 32'h0000_0055, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rw_idle_ready", {31'd0, ready_Q103H}, 32'd1);
        chk("rw_idle_reqv", {31'd0, dmem.dmem_req_valid}, 32'd0);
        push(32'h0000_0055, 1'b0);
        tick();
        sb_check("rw_alu");

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
